// File: rtl/sensor_scan_ctrl_pkg.sv
// Shared types and constants for the sensor mux scan controller.
package sensor_scan_pkg;
    localparam int NUM_CH         = 8;
    localparam int ADDR_W         = 3;
    localparam int CNT_W          = 8;
    localparam int DEFAULT_SETTLE = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WAIT   = 2'd2
    } scan_state_t;
endpackage

// File: rtl/sensor_scan_ctrl_if.sv
// Sample delivery channel: captured sample plus channel tag over valid/ready.
interface sensor_scan_ctrl_if #(
    parameter int DATA_W = 8
);
    import sensor_scan_pkg::*;

    logic [DATA_W-1:0] sample_data;
    logic [ADDR_W-1:0] sample_ch;
    logic              sample_valid;
    logic              sample_ready;

    modport master (output sample_data, sample_ch, sample_valid, input sample_ready);
    modport slave  (input sample_data, sample_ch, sample_valid, output sample_ready);
endinterface

// File: rtl/sensor_scan_ctrl_next_ch.sv
// Channel search: next enabled channel above cur, plus lowest enabled channel.
module scan_next_ch
    import sensor_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [ADDR_W-1:0] cur,
    output logic [ADDR_W-1:0] next_ch,
    output logic              found,
    output logic [ADDR_W-1:0] lowest
);
    // Descending walk so the last hit is the lowest qualifying index.
    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        lowest  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = ADDR_W'(i);
                if (i > int'(cur)) begin
                    next_ch = ADDR_W'(i);
                    found   = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/sensor_scan_ctrl.sv
// Sensor mux scan sequencer: steps enabled channels, settles, captures, hands off.
// Optional per-channel threshold alarms when SENSOR_SCAN_ALARM_EN is defined.
module sensor_scan_ctrl
    import sensor_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE,
    parameter int DATA_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic [DATA_W-1:0]   mux_out,
    output logic [ADDR_W-1:0]   address,
    sensor_scan_ctrl_if.master  smp,
    output logic                busy,
    output logic                scan_done,
    input  logic [DATA_W-1:0]   threshold,
    input  logic                alarm_clr,
    output logic [NUM_CH-1:0]   alarm
);
    scan_state_t       state, state_d;
    logic [NUM_CH-1:0] mask_q, mask_sel;
    logic              cont_q;
    logic              stop_pend;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] nxt_ch, low_ch;
    logic              found;
    logic              scan_start, load_low, load_next, capture, pass_end, hs, stop_eff;

    // In IDLE the live mask picks the first channel; afterwards the latched one.
    assign mask_sel   = (state == IDLE) ? ch_enable : mask_q;
    assign scan_start = (state == IDLE) && start && (|ch_enable);
    assign hs         = (state == WAIT) && smp.sample_valid && smp.sample_ready;
    assign stop_eff   = stop_pend || stop;

    scan_next_ch u_next (
        .mask    (mask_sel),
        .cur     (address),
        .next_ch (nxt_ch),
        .found   (found),
        .lowest  (low_ch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        load_low  = 1'b0;
        load_next = 1'b0;
        capture   = 1'b0;
        pass_end  = 1'b0;
        case (state)
            IDLE: begin
                if (scan_start) begin
                    state_d  = SETTLE;
                    load_low = 1'b1;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt == '0) begin
                    state_d = WAIT;
                    capture = 1'b1;
                end
            end
            WAIT: begin
                if (hs) begin
                    if (found && !stop_eff) begin
                        state_d   = SETTLE;
                        load_next = 1'b1;
                    end else if (cont_q && !stop_eff) begin
                        state_d  = SETTLE;
                        load_low = 1'b1;
                        pass_end = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        pass_end = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address          <= '0;
            cnt              <= '0;
            mask_q           <= '0;
            cont_q           <= 1'b0;
            stop_pend        <= 1'b0;
            scan_done        <= 1'b0;
            smp.sample_data  <= '0;
            smp.sample_ch    <= '0;
            smp.sample_valid <= 1'b0;
        end else begin
            scan_done <= pass_end;
            if (scan_start) begin
                mask_q <= ch_enable;
                cont_q <= continuous;
            end
            if (load_low)       address <= low_ch;
            else if (load_next) address <= nxt_ch;
            if (load_low || load_next)          cnt <= CNT_W'(SETTLE_CYCLES);
            else if (state == SETTLE && cnt != '0) cnt <= cnt - 1'b1;
            if (capture) begin
                smp.sample_data  <= mux_out;
                smp.sample_ch    <= address;
                smp.sample_valid <= 1'b1;
            end else if (hs) begin
                smp.sample_valid <= 1'b0;
            end
            if (state_d == IDLE)              stop_pend <= 1'b0;
            else if (state == WAIT && stop)   stop_pend <= 1'b1;
        end
    end

`ifdef SENSOR_SCAN_ALARM_EN
    logic [NUM_CH-1:0] alarm_set;

    assign alarm_set = (capture && (mux_out > threshold)) ? (NUM_CH'(1) << address) : '0;

    // A capture that trips the threshold survives a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) alarm <= '0;
        else     alarm <= (alarm_clr ? '0 : alarm) | alarm_set;
    end
`else
    logic unused_alarm_in;

    assign unused_alarm_in = ^{threshold, alarm_clr};
    assign alarm           = '0;
`endif
endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed self-checking bench for sensor_scan_ctrl (SETTLE_CYCLES=2, DATA_W=8).
module tb_sensor_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, stop, continuous, alarm_clr;
    logic [7:0] ch_enable, mux_out, threshold, alarm;
    logic [2:0] address;
    logic       busy, scan_done;
    logic       ovr_en;
    logic [7:0] ovr_val;
    int         n_cmp = 0;
    int         n_err = 0;
    int         q_ch[$], q_dat[$], q_cyc[$], q_done[$];

    sensor_scan_ctrl_if #(.DATA_W(8)) smp ();

    sensor_scan_ctrl #(.SETTLE_CYCLES(2), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .ch_enable(ch_enable), .mux_out(mux_out), .address(address), .smp(smp),
        .busy(busy), .scan_done(scan_done), .threshold(threshold),
        .alarm_clr(alarm_clr), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Sensor model: each channel reads 10x its index unless overridden.
    assign mux_out = ovr_en ? ovr_val : 8'(int'(address) * 10);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = smp.sample_valid;
        end
    endtask

    task automatic handshake();
        smp.sample_ready = 1'b1;
        tick();
        smp.sample_ready = 1'b0;
    endtask

    task automatic begin_scan(input logic [7:0] mask, input logic cont);
        ch_enable  = mask;
        continuous = cont;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Runs ncyc cycles with ready high, logging samples and scan_done pulses.
    task automatic collect(input int ncyc, input int inj_cyc);
        q_ch.delete(); q_dat.delete(); q_cyc.delete(); q_done.delete();
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (c == inj_cyc) begin
                start = 1'b1; ch_enable = 8'h80; continuous = 1'b1;
            end else if (c == inj_cyc + 1) begin
                start = 1'b0;
            end
            if (smp.sample_valid) begin
                q_ch.push_back(int'(smp.sample_ch));
                q_dat.push_back(int'(smp.sample_data));
                q_cyc.push_back(c);
            end
            if (scan_done) q_done.push_back(c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; alarm_clr = 1'b0;
        ch_enable = '0; threshold = 8'd40; ovr_en = 1'b0; ovr_val = '0;
        smp.sample_ready = 1'b0;
        #2;
        n_cmp++;
        if ({address, smp.sample_data, smp.sample_ch, smp.sample_valid, busy, scan_done, alarm} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: addr=%0d data=%0d ch=%0d vld=%0b busy=%0b done=%0b alarm=%h want all 0",
                     address, smp.sample_data, smp.sample_ch, smp.sample_valid, busy, scan_done, alarm);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || smp.sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: busy=%0b vld=%0b want 0 0", busy, smp.sample_valid);
        end
    endtask

    task automatic test_basic_scan();
        int exp_ch[4]  = '{0, 2, 5, 7};
        int exp_cyc[4] = '{3, 7, 11, 15};
        smp.sample_ready = 1'b1;
        begin_scan(8'b1010_0101, 1'b0);
        n_cmp++;
        if (address !== 3'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_first_addr: addr=%0d busy=%0b want 0 1", address, busy);
        end
        collect(20, 0);
        n_cmp++;
        if (q_ch.size() !== 4) begin
            n_err++;
            $display("FAIL basic_count: got %0d samples want 4", q_ch.size());
        end
        for (int i = 0; i < 4 && i < q_ch.size(); i++) begin
            n_cmp++;
            if (q_ch[i] !== exp_ch[i] || q_dat[i] !== exp_ch[i] * 10 || q_cyc[i] !== exp_cyc[i]) begin
                n_err++;
                $display("FAIL basic_sample%0d: ch=%0d data=%0d cyc=%0d want ch=%0d data=%0d cyc=%0d",
                         i, q_ch[i], q_dat[i], q_cyc[i], exp_ch[i], exp_ch[i] * 10, exp_cyc[i]);
            end
        end
        n_cmp++;
        if (q_done.size() !== 1 || (q_done.size() == 1 && q_done[0] !== 16)) begin
            n_err++;
            $display("FAIL basic_scan_done: pulses=%0d first=%0d want 1 pulse at 16",
                     q_done.size(), q_done.size() > 0 ? q_done[0] : -1);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy_end: busy=%0b want 0", busy);
        end
        n_cmp++;
`ifdef SENSOR_SCAN_ALARM_EN
        if (alarm !== 8'b1010_0000) begin
            n_err++;
            $display("FAIL alarm_after_basic: alarm=%b want 10100000", alarm);
        end
`else
        if (alarm !== 8'h00) begin
            n_err++;
            $display("FAIL alarm_disabled: alarm=%b want 00000000", alarm);
        end
`endif
    endtask

    task automatic test_backpressure();
        bit ok;
        smp.sample_ready = 1'b0;
        begin_scan(8'b0000_0101, 1'b0);
        wait_valid(20, ok);
        n_cmp++;
        if (!ok || smp.sample_ch !== 3'd0) begin
            n_err++;
            $display("FAIL bp_first: ok=%0b ch=%0d want 1 0", ok, smp.sample_ch);
        end
        handshake();
        wait_valid(20, ok);
        n_cmp++;
        if (!ok || smp.sample_ch !== 3'd2 || smp.sample_data !== 8'd20) begin
            n_err++;
            $display("FAIL bp_ch2: ok=%0b ch=%0d data=%0d want 1 2 20", ok, smp.sample_ch, smp.sample_data);
        end
        ovr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ovr_val = 8'(100 + i);
            tick();
            n_cmp++;
            if (smp.sample_data !== 8'd20 || address !== 3'd2 || smp.sample_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d: data=%0d addr=%0d vld=%0b want 20 2 1",
                         i, smp.sample_data, address, smp.sample_valid);
            end
        end
        ovr_en = 1'b0;
        handshake();
        n_cmp++;
        if (scan_done !== 1'b1 || busy !== 1'b0 || smp.sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_end: done=%0b busy=%0b vld=%0b want 1 0 0", scan_done, busy, smp.sample_valid);
        end
    endtask

    task automatic test_continuous_stop();
        bit ok;
        int exp_addr[4] = '{0, 7, 0, 7};
        smp.sample_ready = 1'b0;
        begin_scan(8'b1000_0001, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_valid(20, ok);
            n_cmp++;
            if (!ok || smp.sample_ch !== 3'(exp_addr[k]) || address !== 3'(exp_addr[k])) begin
                n_err++;
                $display("FAIL cont_addr%0d: ok=%0b ch=%0d addr=%0d want %0d",
                         k, ok, smp.sample_ch, address, exp_addr[k]);
            end
            if (k == 3) break;
            handshake();
            n_cmp++;
            if (scan_done !== (k % 2 == 1) || busy !== 1'b1) begin
                n_err++;
                $display("FAIL cont_done%0d: done=%0b busy=%0b want %0b 1", k, scan_done, busy, k % 2 == 1);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if (smp.sample_valid !== 1'b1 || busy !== 1'b1 || smp.sample_ch !== 3'd7) begin
            n_err++;
            $display("FAIL stop_pending_hold: vld=%0b busy=%0b ch=%0d want 1 1 7",
                     smp.sample_valid, busy, smp.sample_ch);
        end
        handshake();
        n_cmp++;
        if (scan_done !== 1'b1 || busy !== 1'b0 || address !== 3'd7 || smp.sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stop_end: done=%0b busy=%0b addr=%0d vld=%0b want 1 0 7 0",
                     scan_done, busy, address, smp.sample_valid);
        end
        tick();
        n_cmp++;
        if (scan_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stop_idle: done=%0b busy=%0b want 0 0", scan_done, busy);
        end
        continuous = 1'b0;
    endtask

    task automatic test_edge_cases();
        bit quiet = 1'b1;
        smp.sample_ready = 1'b1;
        begin_scan(8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0 || scan_done !== 1'b0 || smp.sample_valid !== 1'b0) quiet = 1'b0;
            tick();
        end
        n_cmp++;
        if (!quiet) begin
            n_err++;
            $display("FAIL empty_mask: activity seen=1 want 0");
        end
        begin_scan(8'b0000_0011, 1'b0);
        collect(14, 2);
        n_cmp++;
        if (q_ch.size() !== 2 || q_ch[0] !== 0 || q_ch[1] !== 1 || q_cyc[0] !== 3 || q_cyc[1] !== 7) begin
            n_err++;
            $display("FAIL busy_start_samples: n=%0d want 2 samples ch0@3 ch1@7", q_ch.size());
        end
        n_cmp++;
        if (q_done.size() !== 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_start_end: done_pulses=%0d busy=%0b want 1 0", q_done.size(), busy);
        end
        continuous = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        bit ok;
        smp.sample_ready = 1'b0;
        begin_scan(8'b0000_1100, 1'b0);
        wait_valid(20, ok);
        n_cmp++;
        if (!ok || smp.sample_ch !== 3'd2) begin
            n_err++;
            $display("FAIL midrst_pre: ok=%0b ch=%0d want 1 2", ok, smp.sample_ch);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({address, smp.sample_data, smp.sample_ch, smp.sample_valid, busy, scan_done} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: addr=%0d data=%0d ch=%0d vld=%0b busy=%0b done=%0b want all 0",
                     address, smp.sample_data, smp.sample_ch, smp.sample_valid, busy, scan_done);
        end
        tick();
        rst = 1'b0;
        smp.sample_ready = 1'b1;
        begin_scan(8'b0000_1100, 1'b0);
        n_cmp++;
        if (address !== 3'd2) begin
            n_err++;
            $display("FAIL midrst_restart_addr: addr=%0d want 2", address);
        end
        collect(10, 0);
        n_cmp++;
        if (q_ch.size() !== 2 || q_ch[0] !== 2 || q_dat[0] !== 20 || q_cyc[0] !== 3 || q_ch[1] !== 3) begin
            n_err++;
            $display("FAIL midrst_rescan: n=%0d want ch2 data20 @3 then ch3", q_ch.size());
        end
    endtask

    task automatic test_alarm();
        smp.sample_ready = 1'b1;
`ifdef SENSOR_SCAN_ALARM_EN
        threshold = 8'd40;
        begin_scan(8'b0010_0000, 1'b0);
        tick(); tick();
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        n_cmp++;
        if (alarm !== 8'b0010_0000 || smp.sample_data !== 8'd50) begin
            n_err++;
            $display("FAIL alarm_set_wins: alarm=%b data=%0d want 00100000 50", alarm, smp.sample_data);
        end
`else
        threshold = 8'd0;
        alarm_clr = 1'b1;
        begin_scan(8'b1000_0000, 1'b0);
        alarm_clr = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (alarm !== 8'h00 || smp.sample_data !== 8'd70) begin
            n_err++;
            $display("FAIL alarm_off: alarm=%b data=%0d want 00000000 70", alarm, smp.sample_data);
        end
`endif
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_continuous_stop();
        test_edge_cases();
        test_reset_mid_scan();
        test_alarm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sensor_scan_ctrl.md
# sensor_scan_ctrl

Sequencing controller for the 8-input sensor multiplexer. It steps the mux `address` through a programmable set of enabled channels and waits a configurable settle time after each address change. It then captures the mux output and delivers each sample with its channel number over a valid/ready handshake. It sits between the sensor mux and the downstream sample consumer (logger/threshold logic), in single-scan or continuous mode.

## Interface
- `SETTLE_CYCLES`, default 2: extra wait cycles after an address change before capture (legal 0..255).
- `DATA_W`, default 8: sample width; must match the mux data width.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin a scan; sampled only in IDLE.
- `stop` input 1: request end of scan.
- `continuous` input 1: latched at start; 1 means wrap and rescan until stopped.
- `ch_enable` input 8: channel mask, latched at start; bit i enables channel i.
- `mux_out` input DATA_W: data from the sensor mux.
- `address` output 3: mux select.
- `sample_data` output DATA_W: captured sample.
- `sample_ch` output 3: channel of `sample_data`.
- `sample_valid` output 1: sample available.
- `sample_ready` input 1: consumer accepts sample.
- `busy` output 1: high whenever state is not IDLE.
- `scan_done` output 1: one-cycle pulse at the end of each pass.
- `threshold` input DATA_W: alarm threshold (see Configuration).
- `alarm_clr` input 1: clear all alarm flags.
- `alarm` output 8: sticky per-channel alarm flags.

## Operation
- States:
  - IDLE: waiting for `start`.
  - SETTLE: address driven, counting settle time.
  - WAIT: sample held, waiting for handshake.
- Reset values: state IDLE, `address` 0, `sample_data` 0, `sample_ch` 0, `sample_valid` 0, `busy` 0, `scan_done` 0, `alarm` 0, settle counter 0, stop-pending 0.
- IDLE with `start`=1 and `ch_enable`≠0:
  - Latch the mask and `continuous`.
  - `address` ← lowest enabled channel; counter ← `SETTLE_CYCLES`; go to SETTLE.
- IDLE with `start`=1 and `ch_enable`=0: ignored, stays IDLE, no `scan_done`.
- SETTLE, counter≠0: decrement.
- SETTLE, counter=0:
  - `sample_data` ← `mux_out`, `sample_ch` ← `address`, `sample_valid` ← 1.
  - Go to WAIT.
- WAIT: `sample_valid`, `sample_data` and `sample_ch` stay stable until the edge where `sample_valid`&`sample_ready`. On that edge `sample_valid` ← 0, then:
  - If an enabled channel exists above `address` and no stop is pending: `address` ← next enabled channel, reload counter, go to SETTLE.
  - Else, if `continuous` and no stop is pending: pulse `scan_done`, `address` ← lowest enabled channel, reload counter, go to SETTLE.
  - Else: pulse `scan_done`, go to IDLE. `address` holds its last value.
- `stop` handling:
  - In SETTLE: return to IDLE next edge, no capture, no `scan_done`.
  - In WAIT: sets stop-pending; the scan ends at the handshake per the rules above. Stop-pending clears on entry to IDLE.
- `start` while busy: ignored. Mask and mode changes take effect only at the next start.
- `ch_enable` with a single bit set: the same channel repeats in continuous mode; `scan_done` pulses on every handshake.

## Timing
- `start` sampled at edge E0: `address` valid after E0. Capture happens at edge E0+`SETTLE_CYCLES`+1. `sample_valid` is high from that edge.
- `mux_out` is therefore given `SETTLE_CYCLES`+1 full cycles with a stable address before capture.
- Handshake at edge Eh: the new `address` is valid after Eh. The next `sample_valid` rises at Eh+`SETTLE_CYCLES`+1.
- With `sample_ready` tied high, throughput is one sample per `SETTLE_CYCLES`+2 cycles.
- `scan_done` is high for exactly the cycle after the final handshake edge of a pass.
- Reset mid-scan: all outputs return to reset values immediately. The in-flight sample is discarded.

## Configuration
- `SENSOR_SCAN_ALARM_EN` defined:
  - At each capture, if `mux_out` > `threshold` (unsigned), set `alarm[address]`.
  - `alarm_clr` clears all flags.
  - Set wins over clear in the same cycle.
- Not defined: `alarm` is constant 0; `threshold` and `alarm_clr` are ignored. Ports stay present so integration is unchanged.

## Structure
- Shared package `sensor_scan_pkg`:
  - State enum (IDLE, SETTLE, WAIT).
  - `NUM_CH`=8, `ADDR_W`=3.
  - Default settle constant.
- One sub-module, `scan_next_ch`: combinational. Given the mask and current address, it returns the next enabled channel above the current one and a found flag, plus the lowest enabled channel.

## Test plan
- Basic scan:
  - Stimulus: `SETTLE_CYCLES`=2, mask 8'b1010_0101, single scan, ready high, `mux_out`=10×address.
  - Required: samples (0,0),(2,20),(5,50),(7,70), spaced 4 cycles apart; one `scan_done`; `busy` falls after it.
- Backpressure:
  - Stimulus: hold `sample_ready` low 10 cycles on channel 2; change `mux_out` meanwhile.
  - Required: `sample_data`=20 is held stable; `address` stays 2 until the handshake.
- Continuous and stop:
  - Stimulus: mask 8'b1000_0001, continuous; assert `stop` during WAIT on channel 7.
  - Required: address sequence 0,7,0,7; `scan_done` on each wrap; IDLE after the pending-stop handshake.
- Edge cases:
  - Stimulus: `start` with mask 0; `start` while busy.
  - Required: no activity and no `scan_done`; the second start is ignored.
- Reset mid-scan:
  - Stimulus: assert `rst` while in WAIT with `sample_valid`=1.
  - Required: all outputs 0 immediately; the next start scans from the lowest enabled channel.
- Alarm, with `SENSOR_SCAN_ALARM_EN` defined:
  - Stimulus: `threshold`=40, data as in the basic scan.
  - Required: `alarm`=8'b1010_0000. Then `alarm_clr` coincident with a channel 5 capture of 50 leaves bit 5 set and bit 7 cleared.
